// File: rtl/move_sched.sv
// Vblank-synchronised command scheduler: request FIFO, engine handshake and undo history stack.
// Optional MOVE_CNT_EN adds a saturating net-move counter output (move_cnt).
`timescale 1ns/1ps
module move_sched #(
    parameter int QDEPTH = 4,
    parameter int HDEPTH = 64,
    parameter int TMO    = 1023
) (
    input  logic                      pixelclk,
    input  logic                      rst,
    input  logic                      key_enU,
    input  logic                      key_enD,
    input  logic                      key_enL,
    input  logic                      key_enR,
    input  logic                      key_enC,
    input  logic                      undo_req,
    input  logic                      restart_req,
    input  logic                      i_vblank,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [2:0]                cmd_op,
    output logic [1:0]                cmd_dir,
    output logic                      cmd_pull,
    input  logic                      done,
    input  logic                      done_moved,
    input  logic                      done_pushed,
    output logic                      busy,
    output logic                      drop,
    output logic [$clog2(HDEPTH):0]   hist_cnt,
`ifdef MOVE_CNT_EN
    output logic [15:0]               move_cnt,
`endif
    output logic                      tmo_err
);

    localparam int QAW = $clog2(QDEPTH);
    localparam int HAW = $clog2(HDEPTH);
    localparam int TW  = $clog2(TMO + 1);
    localparam logic [QAW:0] Q_FULL = (QAW + 1)'(QDEPTH);
    localparam logic [HAW:0] H_FULL = (HAW + 1)'(HDEPTH);

    localparam logic [2:0] OP_UP      = 3'd0;
    localparam logic [2:0] OP_DOWN    = 3'd1;
    localparam logic [2:0] OP_LEFT    = 3'd2;
    localparam logic [2:0] OP_RIGHT   = 3'd3;
    localparam logic [2:0] OP_CONFIRM = 3'd4;
    localparam logic [2:0] OP_UNDO    = 3'd5;
    localparam logic [2:0] OP_RESTART = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_VBL  = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RECORD    = 3'd4
    } state_t;

    state_t            state_r;
    logic [2:0]        q_mem [QDEPTH];
    logic [QAW-1:0]    q_rd_r;
    logic [QAW-1:0]    q_wr_r;
    logic [QAW:0]      q_cnt_r;
    logic [2:0]        h_mem [HDEPTH];
    logic [HAW-1:0]    h_wr_r;
    logic [2:0]        op_r;
    logic              moved_r;
    logic              pushed_r;
    logic [TW-1:0]     tmo_cnt_r;

    logic              req_valid_s;
    logic [2:0]        req_op_s;
    logic              q_empty_s;
    logic              q_full_s;
    logic              push_s;
    logic              pop_s;
    logic              flush_s;
    logic [2:0]        head_s;
    logic [HAW-1:0]    h_top_idx_s;
    logic [2:0]        h_top_s;
    logic              h_we_s;

    assign q_empty_s   = (q_cnt_r == '0);
    assign q_full_s    = (q_cnt_r == Q_FULL);
    assign head_s      = q_mem[q_rd_r];
    assign h_top_idx_s = h_wr_r - HAW'(1);
    assign h_top_s     = h_mem[h_top_idx_s];
    assign busy        = (state_r != S_IDLE) || !q_empty_s;

    // Priority encode coincident request pulses; only the winner is considered for enqueue.
    always_comb begin
        req_valid_s = 1'b1;
        req_op_s    = 3'd0;
        if (restart_req) begin
            req_op_s = OP_RESTART;
        end else if (undo_req) begin
            req_op_s = OP_UNDO;
        end else if (key_enU) begin
            req_op_s = OP_UP;
        end else if (key_enD) begin
            req_op_s = OP_DOWN;
        end else if (key_enL) begin
            req_op_s = OP_LEFT;
        end else if (key_enR) begin
            req_op_s = OP_RIGHT;
        end else if (key_enC) begin
            req_op_s = OP_CONFIRM;
        end else begin
            req_valid_s = 1'b0;
        end
    end

    // FIFO control strobes derived from the request and the FSM dequeue point.
    always_comb begin
        flush_s = req_valid_s && (req_op_s == OP_RESTART);
        push_s  = req_valid_s && !flush_s && !q_full_s;
        pop_s   = (state_r == S_WAIT_VBL) && i_vblank && !q_empty_s;
        h_we_s  = (state_r == S_RECORD) && !op_r[2] && moved_r;
    end

    // Request FIFO storage; a restart always lands in slot 0 of a flushed queue.
    always_ff @(posedge pixelclk) begin
        if (flush_s) begin
            q_mem[0] <= OP_RESTART;
        end else if (push_s) begin
            q_mem[q_wr_r] <= req_op_s;
        end else begin
            q_mem[q_wr_r] <= q_mem[q_wr_r];
        end
    end

    // Request FIFO pointers, occupancy and the drop pulse.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            q_rd_r  <= '0;
            q_wr_r  <= '0;
            q_cnt_r <= '0;
            drop    <= 1'b0;
        end else if (flush_s) begin
            q_rd_r  <= '0;
            q_wr_r  <= QAW'(1);
            q_cnt_r <= (QAW + 1)'(1);
            drop    <= 1'b0;
        end else begin
            drop <= req_valid_s && q_full_s;
            if (push_s) q_wr_r <= q_wr_r + QAW'(1);
            if (pop_s)  q_rd_r <= q_rd_r + QAW'(1);
            case ({push_s, pop_s})
                2'b10:   q_cnt_r <= q_cnt_r + (QAW + 1)'(1);
                2'b01:   q_cnt_r <= q_cnt_r - (QAW + 1)'(1);
                default: q_cnt_r <= q_cnt_r;
            endcase
        end
    end

    // History storage: circular, so a full stack overwrites its oldest entry.
    always_ff @(posedge pixelclk) begin
        if (h_we_s) begin
            h_mem[h_wr_r] <= {op_r[1:0], pushed_r};
        end else begin
            h_mem[h_wr_r] <= h_mem[h_wr_r];
        end
    end

    // Scheduler FSM with registered command outputs and history bookkeeping.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= 3'd0;
            cmd_dir   <= 2'd0;
            cmd_pull  <= 1'b0;
            op_r      <= 3'd0;
            moved_r   <= 1'b0;
            pushed_r  <= 1'b0;
            tmo_cnt_r <= '0;
            tmo_err   <= 1'b0;
            h_wr_r    <= '0;
            hist_cnt  <= '0;
`ifdef MOVE_CNT_EN
            move_cnt  <= 16'd0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!q_empty_s) state_r <= S_WAIT_VBL;
                end
                S_WAIT_VBL: begin
                    if (i_vblank) begin
                        if (q_empty_s) begin
                            state_r <= S_IDLE;
                        end else if (head_s == OP_UNDO && hist_cnt == '0) begin
                            state_r <= S_IDLE;
                        end else begin
                            state_r   <= S_ISSUE;
                            cmd_valid <= 1'b1;
                            cmd_op    <= head_s;
                            op_r      <= head_s;
                            if (head_s == OP_UNDO) begin
                                cmd_dir  <= h_top_s[2:1] ^ 2'b01;
                                cmd_pull <= h_top_s[0];
                            end else begin
                                cmd_dir  <= head_s[1:0];
                                cmd_pull <= 1'b0;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        state_r   <= S_WAIT_DONE;
                        cmd_valid <= 1'b0;
                        tmo_cnt_r <= '0;
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        state_r  <= S_RECORD;
                        moved_r  <= done_moved;
                        pushed_r <= done_pushed;
                    end else if (tmo_cnt_r == TW'(TMO - 1)) begin
                        state_r <= S_IDLE;
                        tmo_err <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                S_RECORD: begin
                    state_r <= S_IDLE;
                    case (op_r)
                        OP_UP, OP_DOWN, OP_LEFT, OP_RIGHT: begin
                            if (moved_r) begin
                                h_wr_r <= h_wr_r + HAW'(1);
                                if (hist_cnt != H_FULL) hist_cnt <= hist_cnt + (HAW + 1)'(1);
`ifdef MOVE_CNT_EN
                                if (move_cnt != 16'hFFFF) move_cnt <= move_cnt + 16'd1;
`endif
                            end
                        end
                        OP_UNDO: begin
                            if (hist_cnt != '0) begin
                                h_wr_r   <= h_top_idx_s;
                                hist_cnt <= hist_cnt - (HAW + 1)'(1);
                            end
`ifdef MOVE_CNT_EN
                            if (move_cnt != 16'd0) move_cnt <= move_cnt - 16'd1;
`endif
                        end
                        OP_RESTART: begin
                            h_wr_r   <= '0;
                            hist_cnt <= '0;
`ifdef MOVE_CNT_EN
                            move_cnt <= 16'd0;
`endif
                        end
                        default: begin
                            hist_cnt <= hist_cnt;
                        end
                    endcase
                end
                default: begin
                    state_r   <= S_IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
